// File: rtl/stream_upsizer.sv
// ---------------------------------------------------------------------------
// stream_upsizer
//
// Packs a narrow valid/ready word stream into full-width lines for the
// line-processing block downstream. Words fill lanes 0, 1, 2, ... of a line.
// A line is presented when all RATIO lanes are filled or when a word marked
// in_last_i arrives, so that packet boundaries survive the width conversion.
// Unwritten lanes read as zero, and their keep bits are clear.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset
//   in_valid_i   input word valid
//   in_ready_o   block can accept an input word
//   in_data_i    input word (IN_W bits)
//   in_last_i    word is the final word of a packet
//   out_valid_o  packed line valid
//   out_ready_i  downstream accepts the line
//   out_data_o   packed line; lane k at [(k+1)*IN_W-1 : k*IN_W]
//   out_keep_o   bit k set means lane k holds a valid word
//   out_last_o   line ends a packet
// ---------------------------------------------------------------------------
module stream_upsizer #(
    parameter int  IN_W  = 32,
    parameter int  OUT_W = 512,
    localparam int RATIO = OUT_W / IN_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic [RATIO-1:0] out_keep_o,
    output logic             out_last_o
);

    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [RATIO-1:0][IN_W-1:0]   data_q, data_d;
    logic [RATIO-1:0]             keep_q, keep_d;
    logic                         last_q, last_d;
    logic                         in_fire;

    // While a line is held, the drain cycle passes ready straight through so
    // the next word can start a fresh line without a bubble.
    assign in_ready_o  = (state_q == FILL) ? 1'b1 : out_ready_i;
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == HOLD);
    assign out_keep_o  = keep_q;
    assign out_last_o  = last_q;

    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            assign out_data_o[gi*IN_W +: IN_W] = data_q[gi];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;

        case (state_q)
            FILL: begin
                if (in_fire) begin
                    data_d[idx_q] = in_data_i;
                    keep_d[idx_q] = 1'b1;
                    if ((idx_q == IDX_W'(RATIO - 1)) || in_last_i) begin
                        state_d = HOLD;
                        last_d  = in_last_i;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            HOLD: begin
                if (out_ready_i) begin
                    // Line consumed: start from an all-zero line so that
                    // lanes never written in the next line read as zero.
                    data_d = '0;
                    keep_d = '0;
                    last_d = 1'b0;
                    idx_d  = '0;
                    state_d = FILL;
                    if (in_fire) begin
                        data_d[0] = in_data_i;
                        keep_d[0] = 1'b1;
                        if (in_last_i) begin
                            // Single-word packet: the fresh line is complete.
                            state_d = HOLD;
                            last_d  = 1'b1;
                        end else begin
                            idx_d = IDX_W'(1);
                        end
                    end
                end
            end

            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL;
            idx_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// ---------------------------------------------------------------------------
// tb_stream_upsizer
//
// Self-checking bench for stream_upsizer (IN_W=32, OUT_W=512). A reference
// model chops the accepted word stream into lines (RATIO words, or fewer when
// a word carries last) and keeps a queue of lines awaiting the downstream
// handshake. Each scenario task drives cycles and compares the sampled DUT
// outputs against the model and against directed constants.
// ---------------------------------------------------------------------------
module tb_stream_upsizer;

    localparam int IN_W  = 32;
    localparam int OUT_W = 512;
    localparam int RATIO = OUT_W / IN_W;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [RATIO-1:0] keep;
        logic             last;
    } line_t;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [IN_W-1:0]  in_data_i = '0;
    logic             in_last_i = 1'b0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [OUT_W-1:0] out_data_o;
    logic [RATIO-1:0] out_keep_o;
    logic             out_last_o;

    int asserts = 0;
    int fails   = 0;

    // Reference model state
    line_t            exp_q[$];
    logic [OUT_W-1:0] part_data;
    logic [RATIO-1:0] part_keep;
    int               part_cnt;

    // Expectations and observations for the most recent cycle
    bit               exp_valid, exp_ready;
    line_t            exp_line;
    logic             obs_ready, obs_valid, obs_last;
    logic [OUT_W-1:0] obs_data;
    logic [RATIO-1:0] obs_keep;

    stream_upsizer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_keep_o  (out_keep_o),
        .out_last_o  (out_last_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void model_clear();
        exp_q.delete();
        part_data = '0;
        part_keep = '0;
        part_cnt  = 0;
    endfunction

    function automatic void model_word(input logic [IN_W-1:0] d, input bit l);
        line_t ln;
        part_data[part_cnt*IN_W +: IN_W] = d;
        part_keep[part_cnt] = 1'b1;
        part_cnt++;
        if (part_cnt == RATIO || l) begin
            ln.data = part_data;
            ln.keep = part_keep;
            ln.last = l;
            exp_q.push_back(ln);
            part_data = '0;
            part_keep = '0;
            part_cnt  = 0;
        end
    endfunction

    // One clock cycle: drive inputs, sample outputs at the falling edge,
    // then advance the model by the handshakes the spec says must occur.
    task automatic cyc(input bit rst, input bit v, input bit l, input bit r,
                       input logic [IN_W-1:0] d);
        rst_i       = rst;
        in_valid_i  = v;
        in_last_i   = l;
        out_ready_i = r;
        in_data_i   = d;
        exp_valid   = (exp_q.size() > 0);
        exp_ready   = !exp_valid || r;
        if (exp_valid) exp_line = exp_q[0];
        else begin
            exp_line.data = '0;
            exp_line.keep = '0;
            exp_line.last = 1'b0;
        end
        @(negedge clk_i);
        obs_ready = in_ready_o;
        obs_valid = out_valid_o;
        obs_data  = out_data_o;
        obs_keep  = out_keep_o;
        obs_last  = out_last_o;
        @(posedge clk_i);
        #1;
        if (rst) model_clear();
        else begin
            if (exp_valid && r) void'(exp_q.pop_front());
            if (v && exp_ready) model_word(d, l);
        end
    endtask

    task automatic test_reset();
        cyc(1, 1, 0, 0, 32'hDEAD_BEEF);
        cyc(1, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);
        asserts++;
        if (obs_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", obs_valid); end
        asserts++;
        if (obs_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", obs_ready); end
        asserts++;
        if (obs_keep !== '0 || obs_last !== 1'b0 || obs_data !== '0) begin
            fails++; $display("FAIL reset_regs keep=%h last=%b data!=0 want keep=0 last=0 data=0", obs_keep, obs_last);
        end
    endtask

    task automatic test_full_line();
        logic [OUT_W-1:0] want;
        int stalls = 0;
        want = '0;
        for (int k = 0; k < RATIO; k++) begin
            want[k*IN_W +: IN_W] = IN_W'(k);
            cyc(0, 1, 0, 1, IN_W'(k));
            if (obs_ready !== 1'b1 || obs_valid !== 1'b0) stalls++;
        end
        asserts++;
        if (stalls != 0) begin fails++; $display("FAIL full_fill_flags %0d bad cycles want 0", stalls); end
        cyc(0, 0, 0, 1, '0);
        asserts++;
        if (obs_valid !== 1'b1) begin fails++; $display("FAIL full_valid got %b want 1", obs_valid); end
        asserts++;
        if (obs_data !== want || obs_keep !== 16'hFFFF || obs_last !== 1'b0) begin
            fails++; $display("FAIL full_line data=%h keep=%h last=%b want data=%h keep=ffff last=0", obs_data, obs_keep, obs_last, want);
        end
    endtask

    task automatic test_short_packet();
        logic [OUT_W-1:0] want;
        want = '0;
        want[31:0] = 32'hA; want[63:32] = 32'hB; want[95:64] = 32'hC;
        cyc(0, 1, 0, 1, 32'hA);
        cyc(0, 1, 0, 1, 32'hB);
        cyc(0, 1, 1, 1, 32'hC);
        cyc(0, 0, 0, 1, '0);
        asserts++;
        if (obs_valid !== 1'b1 || obs_data !== want || obs_keep !== 16'h0007 || obs_last !== 1'b1) begin
            fails++; $display("FAIL short_line valid=%b keep=%h last=%b data=%h want valid=1 keep=0007 last=1 data=%h",
                              obs_valid, obs_keep, obs_last, obs_data, want);
        end
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] want;
        int bad = 0;
        for (int k = 0; k < RATIO; k++) cyc(0, 1, 0, 0, $urandom);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 0, 0, 32'h55);
            if (obs_ready !== 1'b0 || obs_valid !== 1'b1 || obs_data !== exp_line.data ||
                obs_keep !== 16'hFFFF || obs_last !== 1'b0) bad++;
        end
        asserts++;
        if (bad != 0) begin fails++; $display("FAIL bp_hold %0d unstable/ready cycles want 0", bad); end
        cyc(0, 1, 0, 1, 32'h55);
        asserts++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b1 || obs_data !== exp_line.data) begin
            fails++; $display("FAIL bp_release ready=%b valid=%b want ready=1 valid=1 data match", obs_ready, obs_valid);
        end
        cyc(0, 1, 1, 0, 32'h66);
        asserts++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
            fails++; $display("FAIL bp_refill ready=%b valid=%b want ready=1 valid=0", obs_ready, obs_valid);
        end
        want = '0;
        want[31:0] = 32'h55; want[63:32] = 32'h66;
        cyc(0, 0, 0, 1, '0);
        asserts++;
        if (obs_valid !== 1'b1 || obs_data !== want || obs_keep !== 16'h0003 || obs_last !== 1'b1) begin
            fails++; $display("FAIL bp_newline valid=%b keep=%h last=%b data=%h want valid=1 keep=0003 last=1 data=%h",
                              obs_valid, obs_keep, obs_last, obs_data, want);
        end
    endtask

    task automatic test_back_to_back();
        int stalls = 0, lines = 0, bad = 0;
        for (int k = 0; k <= 3 * RATIO; k++) begin
            if (k < 3 * RATIO) cyc(0, 1, 0, 1, $urandom);
            else               cyc(0, 0, 0, 1, '0);
            if (k < 3 * RATIO && obs_ready !== 1'b1) stalls++;
            if (obs_valid === 1'b1) begin
                lines++;
                if (!exp_valid || obs_data !== exp_line.data || obs_keep !== 16'hFFFF || obs_last !== 1'b0) bad++;
            end
        end
        asserts++;
        if (stalls != 0) begin fails++; $display("FAIL b2b_stalls got %0d want 0", stalls); end
        asserts++;
        if (lines != 3) begin fails++; $display("FAIL b2b_lines got %0d want 3", lines); end
        asserts++;
        if (bad != 0) begin fails++; $display("FAIL b2b_content %0d bad lines want 0", bad); end
    endtask

    task automatic test_single_word();
        int lines = 0, bad = 0;
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) cyc(0, 1, 1, 1, $urandom);
            else        cyc(0, 0, 0, 1, '0);
            if (k >= 1) begin
                if (obs_valid === 1'b1) lines++;
                if (obs_valid !== 1'b1 || obs_keep !== 16'h0001 || obs_last !== 1'b1 ||
                    obs_data !== exp_line.data || (k < 10 && obs_ready !== 1'b1)) bad++;
            end
        end
        asserts++;
        if (lines != 10) begin fails++; $display("FAIL single_lines got %0d want 10", lines); end
        asserts++;
        if (bad != 0) begin fails++; $display("FAIL single_content %0d bad cycles want 0", bad); end
    endtask

    task automatic test_reset_mid_line();
        logic [IN_W-1:0] first;
        for (int k = 0; k < 7; k++) cyc(0, 1, 0, 1, $urandom);
        cyc(1, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);
        asserts++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            fails++; $display("FAIL rstmid_flags valid=%b ready=%b want valid=0 ready=1", obs_valid, obs_ready);
        end
        first = $urandom;
        cyc(0, 1, 0, 1, first);
        for (int k = 1; k < RATIO; k++) cyc(0, 1, 0, 1, $urandom);
        cyc(0, 0, 0, 1, '0);
        asserts++;
        if (obs_valid !== 1'b1 || obs_data[IN_W-1:0] !== first || obs_keep !== 16'hFFFF ||
            obs_data !== exp_line.data) begin
            fails++; $display("FAIL rstmid_line valid=%b lane0=%h keep=%h want valid=1 lane0=%h keep=ffff",
                              obs_valid, obs_data[IN_W-1:0], obs_keep, first);
        end
    endtask

    task automatic test_random();
        int bad_flags = 0, bad_lines = 0;
        for (int k = 0; k < 400; k++) begin
            cyc(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 2) != 0), $urandom);
            if (obs_ready !== exp_ready || obs_valid !== exp_valid) bad_flags++;
            if (exp_valid && (obs_data !== exp_line.data || obs_keep !== exp_line.keep ||
                              obs_last !== exp_line.last)) bad_lines++;
        end
        cyc(0, 0, 0, 1, '0);
        asserts++;
        if (bad_flags != 0) begin fails++; $display("FAIL rand_handshake %0d bad cycles want 0", bad_flags); end
        asserts++;
        if (bad_lines != 0) begin fails++; $display("FAIL rand_lines %0d bad cycles want 0", bad_lines); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_full_line();
        test_short_packet();
        test_backpressure();
        test_back_to_back();
        test_single_word();
        test_reset_mid_line();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
